dense_row_sequencer: RTL and testbench

Frame controller in front of `dense_int_front`. On a start pulse it reads the H input rows of one feature map from a synchronous row buffer and streams them to the dense core as H back-to-back valid cycles. It then collects the BIAS scalar results the core returns, tags each with its neuron index, and signals frame completion. It sits between the feature-map row buffer and the dense core, and is the only block that drives the core's `valid_i`/`data_i`.

---
 rtl/dense_row_sequencer.sv | 150 +++++++++++++++
 tb/tb_dense_row_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_row_sequencer.sv
// Frame controller for the dense core. It streams H buffer rows back-to-back, then
// tags the BIAS returned scalars with neuron indices and pulses done.
module dense_row_sequencer #(
  parameter int H          = 2,
  parameter int W          = 2,
  parameter int DEPTH      = 64,
  parameter int BIAS       = 128,
  parameter int DATA_WIDTH = 32,
  parameter int ROW_W      = DATA_WIDTH * W * DEPTH,
  parameter int ADDR_W     = (H > 1) ? $clog2(H) : 1,
  parameter int IDX_W      = (BIAS > 1) ? $clog2(BIAS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  rd_en_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  input  logic [ROW_W-1:0]      rd_data_i,
  output logic                  core_valid_o,
  output logic [ROW_W-1:0]      core_data_o,
  input  logic                  core_valid_i,
  input  logic [DATA_WIDTH-1:0] core_data_i,
  output logic                  res_valid_o,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic [IDX_W-1:0]      res_idx_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] row_cnt;
  logic [IDX_W-1:0]  res_cnt;
  logic              start_acc;
  logic              res_acc;
  logic              last_row;
  logic              last_res;

  assign start_acc = (state == IDLE) && start_i;
  assign res_acc   = core_valid_i && (state != IDLE);
  assign last_row  = (row_cnt == ADDR_W'(H - 1));
  assign last_res  = res_acc && (res_cnt == IDX_W'(BIAS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort outranks completion; completion can land in FEED when the core is fast.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = FEED;
        end
      end
      FEED: begin
        if (abort_i || last_res) begin
          state_nxt = IDLE;
        end else if (last_row) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i || last_res) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy_o    = (state != IDLE);
  assign rd_en_o   = (state == FEED);
  assign rd_addr_o = row_cnt;

  // Row counter only advances while staying in FEED, so it rests at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
    end else if ((state == FEED) && (state_nxt == FEED)) begin
      row_cnt <= row_cnt + 1'b1;
    end else begin
      row_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (start_acc) begin
      res_cnt <= '0;
    end else if (res_acc) begin
      res_cnt <= res_cnt + 1'b1;
    end
  end

  // The buffer answers one cycle after the read strobe; the data is passed straight on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_valid_o <= 1'b0;
    end else begin
      core_valid_o <= rd_en_o;
    end
  end

  assign core_data_o = core_valid_o ? rd_data_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_idx_o   <= '0;
      done_o      <= 1'b0;
    end else begin
      res_valid_o <= res_acc;
      done_o      <= last_res && !abort_i;
      if (res_acc) begin
        res_data_o <= core_data_i;
        res_idx_o  <= res_cnt;
      end
    end
  end

  // A result arriving with no frame open is dropped and flagged until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_o <= 1'b0;
    end else if (start_acc) begin
      error_o <= 1'b0;
    end else if ((state == IDLE) && core_valid_i) begin
      error_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dense_row_sequencer.sv
// Directed bench for dense_row_sequencer with a transaction-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_dense_row_sequencer;
  localparam int H          = 2;
  localparam int W          = 2;
  localparam int DEPTH      = 2;
  localparam int BIAS       = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ROW_W      = DATA_WIDTH * W * DEPTH;
  localparam int ADDR_W     = 1;
  localparam int IDX_W      = 2;

  typedef logic [ROW_W-1:0] w_t;

  localparam w_t ROW0 = {4{32'h3DCC_CCCD}};
  localparam w_t ROW1 = {4{32'h3F8C_CCCD}};

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_i;
  logic                  abort_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic                  rd_en_o;
  logic [ADDR_W-1:0]     rd_addr_o;
  logic [ROW_W-1:0]      rd_data_i;
  logic                  core_valid_o;
  logic [ROW_W-1:0]      core_data_o;
  logic                  core_valid_i;
  logic [DATA_WIDTH-1:0] core_data_i;
  logic                  res_valid_o;
  logic [DATA_WIDTH-1:0] res_data_o;
  logic [IDX_W-1:0]      res_idx_o;

  dense_row_sequencer #(
    .H(H), .W(W), .DEPTH(DEPTH), .BIAS(BIAS), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .core_valid_o(core_valid_o), .core_data_o(core_data_o),
    .core_valid_i(core_valid_i), .core_data_i(core_data_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_idx_o(res_idx_o)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cv_cnt   = 0;
  w_t mem [H];

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Synchronous row buffer: the strobe seen in a cycle yields data after the next edge.
  initial begin : row_buffer
    logic             en;
    logic [ADDR_W-1:0] addr;
    rd_data_i = '0;
    forever begin
      @(negedge clk);
      en   = rd_en_o;
      addr = rd_addr_o;
      @(posedge clk);
      #1;
      if (en) rd_data_i = mem[addr];
    end
  end

  // Reference model: frame progress kept as plain counts of rows issued and results seen.
  bit                    m_active, m_err, m_cv, m_rv, m_done;
  int                    m_rows, m_nres, m_cv_row, m_ridx;
  logic [DATA_WIDTH-1:0] m_rdat;

  always @(posedge clk or posedge rst) begin : model
    bit was_rd;
    int was_row;
    if (rst) begin
      m_active = 0; m_err = 0; m_cv = 0; m_rv = 0; m_done = 0;
      m_rows = 0; m_nres = 0; m_cv_row = 0; m_ridx = 0; m_rdat = '0;
    end else begin
      was_rd   = m_active && (m_rows < H);
      was_row  = m_rows;
      m_cv     = was_rd;
      m_cv_row = was_row;
      m_rv     = 0;
      m_done   = 0;
      if (m_active) begin
        if (core_valid_i) begin
          m_rv = 1; m_rdat = core_data_i; m_ridx = m_nres; m_nres++;
        end
        if (abort_i) m_active = 0;
        else if (m_nres == BIAS) begin m_active = 0; m_done = 1; end
        else if (was_rd) m_rows++;
      end else begin
        if (core_valid_i) m_err = 1;
        if (start_i) begin m_active = 1; m_rows = 0; m_nres = 0; m_err = 0; end
      end
    end
  end

  initial begin : compare
    bit e_rd;
    int e_addr;
    forever begin
      @(negedge clk);
      e_rd   = m_active && (m_rows < H);
      e_addr = e_rd ? m_rows : 0;
      chk("busy", w_t'(busy_o), w_t'(m_active));
      chk("rd_en", w_t'(rd_en_o), w_t'(e_rd));
      chk("rd_addr", w_t'(rd_addr_o), w_t'(e_addr));
      chk("core_valid", w_t'(core_valid_o), w_t'(m_cv));
      chk("core_data", core_data_o, m_cv ? mem[m_cv_row] : w_t'(0));
      chk("res_valid", w_t'(res_valid_o), w_t'(m_rv));
      chk("res_data", w_t'(res_data_o), w_t'(m_rdat));
      chk("res_idx", w_t'(res_idx_o), w_t'(m_ridx));
      chk("done", w_t'(done_o), w_t'(m_done));
      chk("error", w_t'(error_o), w_t'(m_err));
      if (done_o) done_cnt++;
      if (core_valid_o) cv_cnt++;
    end
  end

  task automatic result(input logic [DATA_WIDTH-1:0] d, input logic st);
    core_valid_i = 1'b1;
    core_data_i  = d;
    step(1);
    core_valid_i = 1'b0;
    start_i      = st;
  endtask

  task automatic full_frame(input logic [DATA_WIDTH-1:0] base);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(3);
    for (int i = 0; i < BIAS; i++) begin
      result(base + DATA_WIDTH'(i), 1'b0);
      if (i < BIAS - 1) step(2);
    end
  endtask

  initial begin : stimulus
    int base_done;
    int base_cv;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    core_valid_i = 1'b0; core_data_i = '0;
    mem[0] = ROW0;
    mem[1] = ROW1;
    step(3);
    @(negedge clk);
    chk("rst_busy", w_t'(busy_o), w_t'(0));
    chk("rst_rd_en", w_t'(rd_en_o), w_t'(0));
    chk("rst_res_idx", w_t'(res_idx_o), w_t'(0));
    rst = 1'b0;
    step(2);

    // Frame 1: row streaming pinned literally
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    @(negedge clk);
    chk("f1_rd_en0", w_t'(rd_en_o), w_t'(1));
    chk("f1_addr0", w_t'(rd_addr_o), w_t'(0));
    chk("f1_cv0", w_t'(core_valid_o), w_t'(0));
    @(negedge clk);
    chk("f1_addr1", w_t'(rd_addr_o), w_t'(1));
    chk("f1_cv1", w_t'(core_valid_o), w_t'(1));
    chk("f1_row0", core_data_o, ROW0);
    @(negedge clk);
    chk("f1_rd_en_off", w_t'(rd_en_o), w_t'(0));
    chk("f1_cv2", w_t'(core_valid_o), w_t'(1));
    chk("f1_row1", core_data_o, ROW1);
    step(1);
    for (int i = 0; i < BIAS; i++) begin
      result(32'hC0DE_0010 + 32'(i), (i == BIAS - 1));
      if (i < BIAS - 1) step(2);
    end
    @(negedge clk);
    chk("f1_done", w_t'(done_o), w_t'(1));
    chk("f1_last_idx", w_t'(res_idx_o), w_t'(3));
    chk("f1_last_data", w_t'(res_data_o), w_t'(32'hC0DE_0013));
    chk("f1_busy_low", w_t'(busy_o), w_t'(0));

    // Frame 2: accepted back-to-back, stray start in DRAIN ignored
    step(1);
    start_i = 1'b0;
    base_done = done_cnt;
    @(negedge clk);
    chk("f2_b2b_rd_en", w_t'(rd_en_o), w_t'(1));
    chk("f2_b2b_addr", w_t'(rd_addr_o), w_t'(0));
    step(2);
    result(32'hBEEF_0020, 1'b0);
    step(2);
    result(32'hBEEF_0021, 1'b1);
    step(1);
    start_i = 1'b0;
    step(1);
    result(32'hBEEF_0022, 1'b0);
    step(2);
    result(32'hBEEF_0023, 1'b0);
    @(negedge clk);
    chk("f2_done_idx", w_t'(res_idx_o), w_t'(3));
    step(3);
    chk("f2_one_done", w_t'(done_cnt - base_done), w_t'(1));
    chk("f2_idle", w_t'(busy_o), w_t'(0));

    // Frame 3: abort after first read, then a stray result
    base_done = done_cnt;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    abort_i = 1'b1;
    base_cv = cv_cnt;
    step(1);
    abort_i = 1'b0;
    @(negedge clk);
    chk("ab_rd_en", w_t'(rd_en_o), w_t'(0));
    chk("ab_busy", w_t'(busy_o), w_t'(0));
    chk("ab_cv_inflight", w_t'(core_valid_o), w_t'(1));
    step(3);
    chk("ab_cv_once", w_t'(cv_cnt - base_cv), w_t'(1));
    result(32'hDEAD_0030, 1'b0);
    @(negedge clk);
    chk("ab_error", w_t'(error_o), w_t'(1));
    chk("ab_no_res", w_t'(res_valid_o), w_t'(0));
    step(3);
    chk("ab_error_sticky", w_t'(error_o), w_t'(1));
    chk("ab_no_done", w_t'(done_cnt - base_done), w_t'(0));

    // Frame 4: reset during DRAIN after two results
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    @(negedge clk);
    chk("f4_error_clr", w_t'(error_o), w_t'(0));
    step(2);
    result(32'hA5A5_0040, 1'b0);
    step(2);
    result(32'hA5A5_0041, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_busy", w_t'(busy_o), w_t'(0));
    chk("ar_res_valid", w_t'(res_valid_o), w_t'(0));
    chk("ar_res_idx", w_t'(res_idx_o), w_t'(0));
    chk("ar_res_data", w_t'(res_data_o), w_t'(0));
    chk("ar_core_valid", w_t'(core_valid_o), w_t'(0));
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // Frame 5: recovery after reset
    base_done = done_cnt;
    full_frame(32'h5A5A_0050);
    @(negedge clk);
    chk("f5_done", w_t'(done_o), w_t'(1));
    chk("f5_idx", w_t'(res_idx_o), w_t'(3));
    step(3);
    chk("f5_one_done", w_t'(done_cnt - base_done), w_t'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
